// File: rtl/procyon_lsu_pkg.sv
// Shared LSU definitions: load-queue entry states, byte-mask width and lsu_func size mapping.
// The PCYN_LSU_FUNC_* encodings mirror the codebase's constants header.
package procyon_lsu_pkg;

  localparam int PCYN_LSU_FUNC_WIDTH = 4;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LB  = 4'd0;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LH  = 4'd1;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LW  = 4'd2;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LBU = 4'd3;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LHU = 4'd4;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SB  = 4'd5;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SH  = 4'd6;
  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_SW  = 4'd7;

  localparam int PCYN_LQ_MASK_WIDTH = 4;

  typedef enum logic [2:0] {
    LQ_STATE_INVALID       = 3'd0,
    LQ_STATE_LAUNCHED      = 3'd1,
    LQ_STATE_MHQ_FILL_WAIT = 3'd2,
    LQ_STATE_REPLAYABLE    = 3'd3,
    LQ_STATE_COMPLETE      = 3'd4
  } lq_state_t;

  // Byte-enable pattern for an access at byte offset 0 of its word.
  function automatic logic [PCYN_LQ_MASK_WIDTH-1:0] lsu_func_size_mask(
    input logic [PCYN_LSU_FUNC_WIDTH-1:0] lsu_func
  );
    case (lsu_func)
      PCYN_LSU_FUNC_LB, PCYN_LSU_FUNC_LBU, PCYN_LSU_FUNC_SB: return 4'b0001;
      PCYN_LSU_FUNC_LH, PCYN_LSU_FUNC_LHU, PCYN_LSU_FUNC_SH: return 4'b0011;
      default:                                               return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/procyon_lsu_lq_if.sv
// LSU-side bundle of the load queue: allocation, replay and update channels.
interface procyon_lsu_lq_if
  import procyon_lsu_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_ROB_IDX_WIDTH = 5
);
  // Alloc is a one-cycle push with no backpressure (caller honours o_full).
  // Replay is valid/stall: o_replay_* hold their value while i_replay_stall is high.
  logic                           i_alloc_en;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_alloc_lsu_func;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_alloc_tag;
  logic [OPTN_ADDR_WIDTH-1:0]     i_alloc_addr;
  logic [OPTN_LQ_DEPTH-1:0]       o_alloc_select;
  logic                           i_replay_stall;
  logic                           o_replay_en;
  logic [OPTN_LQ_DEPTH-1:0]       o_replay_select;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] o_replay_lsu_func;
  logic [OPTN_ADDR_WIDTH-1:0]     o_replay_addr;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  o_replay_tag;
  logic                           i_update_en;
  logic [OPTN_LQ_DEPTH-1:0]       i_update_select;
  logic                           i_update_retry;
  logic                           i_update_mhq_retry;

  modport master (
    output i_alloc_en, i_alloc_lsu_func, i_alloc_tag, i_alloc_addr,
    input  o_alloc_select,
    output i_replay_stall,
    input  o_replay_en, o_replay_select, o_replay_lsu_func, o_replay_addr, o_replay_tag,
    output i_update_en, i_update_select, i_update_retry, i_update_mhq_retry
  );

  modport slave (
    input  i_alloc_en, i_alloc_lsu_func, i_alloc_tag, i_alloc_addr,
    output o_alloc_select,
    input  i_replay_stall,
    output o_replay_en, o_replay_select, o_replay_lsu_func, o_replay_addr, o_replay_tag,
    input  i_update_en, i_update_select, i_update_retry, i_update_mhq_retry
  );
endinterface

// File: rtl/procyon_lsu_lq_overlap.sv
// Byte-overlap test between one queued load and the retiring store.
module procyon_lsu_lq_overlap
  import procyon_lsu_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH = 32
) (
  input  logic [OPTN_ADDR_WIDTH-1:0]     load_addr,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] load_lsu_func,
  input  logic [OPTN_ADDR_WIDTH-1:0]     store_addr,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] store_lsu_func,
  output logic                           overlap
);
  logic [PCYN_LQ_MASK_WIDTH-1:0] load_mask;
  logic [PCYN_LQ_MASK_WIDTH-1:0] store_mask;

  always_comb begin
    load_mask  = lsu_func_size_mask(load_lsu_func) << load_addr[1:0];
    store_mask = lsu_func_size_mask(store_lsu_func) << store_addr[1:0];
    overlap    = (load_addr[OPTN_ADDR_WIDTH-1:2] == store_addr[OPTN_ADDR_WIDTH-1:2]) &&
                 ((load_mask & store_mask) != '0);
  end
endmodule

// File: rtl/procyon_lsu_lq.sv
// Load queue: tracks loads from issue to ROB retire, replays retried loads, flags stale reads.
// Optional macro PCYN_LQ_PERF_COUNTERS_EN adds misspeculation and replay counters.
module procyon_lsu_lq
  import procyon_lsu_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_ROB_IDX_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_flush,
  output logic                           o_full,
  procyon_lsu_lq_if.slave                lq_if,
  input  logic                           i_mhq_fill_en,
  input  logic                           i_sq_retire_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_sq_retire_addr,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_sq_retire_lsu_func,
  input  logic                           i_rob_retire_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]  i_rob_retire_tag,
  output logic                           o_rob_retire_ack,
  output logic                           o_rob_retire_misspeculated
`ifdef PCYN_LQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]                    o_misspec_count,
  output logic [31:0]                    o_replay_count
`endif
);
  localparam int D = OPTN_LQ_DEPTH;

  if (((D & (D - 1)) != 0) || ((OPTN_DATA_WIDTH % 8) != 0)) begin : g_bad_param
    $error("procyon_lsu_lq: depth must be a power of two and data width a byte multiple");
  end

  lq_state_t                      entry_state      [D];
  lq_state_t                      entry_state_next [D];
  logic [PCYN_LSU_FUNC_WIDTH-1:0] entry_func       [D];
  logic [OPTN_ADDR_WIDTH-1:0]     entry_addr       [D];
  logic [OPTN_ROB_IDX_WIDTH-1:0]  entry_tag        [D];
  logic [D-1:0]                   entry_misspec;

  logic [D-1:0] empty, replayable, overlap, sq_hit, retire_match;
  logic [D-1:0] alloc_select, replay_select;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] replay_func_mux;
  logic [OPTN_ADDR_WIDTH-1:0]     replay_addr_mux;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  replay_tag_mux;
  logic retire_ack_next, retire_misspec_next;
  logic                           replay_en;
  logic [D-1:0]                   replay_select_q;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] replay_func_q;
  logic [OPTN_ADDR_WIDTH-1:0]     replay_addr_q;
  logic [OPTN_ROB_IDX_WIDTH-1:0]  replay_tag_q;

  for (genvar g = 0; g < D; g++) begin : g_overlap
    procyon_lsu_lq_overlap #(.OPTN_ADDR_WIDTH(OPTN_ADDR_WIDTH)) overlap_inst (
      .load_addr     (entry_addr[g]),
      .load_lsu_func (entry_func[g]),
      .store_addr    (i_sq_retire_addr),
      .store_lsu_func(i_sq_retire_lsu_func),
      .overlap       (overlap[g])
    );
  end

  // Only loads that already read memory can be stale; waiting/replayable ones re-read later.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      empty[i]        = (entry_state[i] == LQ_STATE_INVALID);
      replayable[i]   = (entry_state[i] == LQ_STATE_REPLAYABLE);
      sq_hit[i]       = i_sq_retire_en && overlap[i] &&
                        ((entry_state[i] == LQ_STATE_LAUNCHED) || (entry_state[i] == LQ_STATE_COMPLETE));
      retire_match[i] = i_rob_retire_en && (entry_state[i] == LQ_STATE_COMPLETE) &&
                        (entry_tag[i] == i_rob_retire_tag);
    end
    alloc_select  = lq_if.i_alloc_en ? (empty & (-empty)) : '0;
    replay_select = lq_if.i_replay_stall ? '0 : (replayable & (-replayable));
    o_full        = ((empty & ~alloc_select) == '0);
    retire_ack_next     = |retire_match;
    retire_misspec_next = |(retire_match & (entry_misspec | sq_hit));
  end

  always_comb begin
    replay_func_mux = '0;
    replay_addr_mux = '0;
    replay_tag_mux  = '0;
    for (int i = 0; i < D; i++) begin
      if (replay_select[i]) begin
        replay_func_mux = entry_func[i];
        replay_addr_mux = entry_addr[i];
        replay_tag_mux  = entry_tag[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < D; i++) begin
      entry_state_next[i] = entry_state[i];
      if (i_flush) begin
        entry_state_next[i] = LQ_STATE_INVALID;
      end else begin
        case (entry_state[i])
          LQ_STATE_INVALID:
            if (alloc_select[i]) entry_state_next[i] = LQ_STATE_LAUNCHED;
          LQ_STATE_LAUNCHED:
            if (lq_if.i_update_en && lq_if.i_update_select[i]) begin
              if (!lq_if.i_update_retry)
                entry_state_next[i] = LQ_STATE_COMPLETE;
              else if (lq_if.i_update_mhq_retry && !i_mhq_fill_en)
                entry_state_next[i] = LQ_STATE_MHQ_FILL_WAIT;
              else
                entry_state_next[i] = LQ_STATE_REPLAYABLE;
            end
          LQ_STATE_MHQ_FILL_WAIT:
            if (i_mhq_fill_en) entry_state_next[i] = LQ_STATE_REPLAYABLE;
          LQ_STATE_REPLAYABLE:
            if (replay_select[i]) entry_state_next[i] = LQ_STATE_LAUNCHED;
          LQ_STATE_COMPLETE:
            if (retire_match[i]) entry_state_next[i] = LQ_STATE_INVALID;
          default:
            entry_state_next[i] = LQ_STATE_INVALID;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (!n_rst) entry_state[i] <= LQ_STATE_INVALID;
      else        entry_state[i] <= entry_state_next[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (!i_flush && alloc_select[i]) begin
        entry_func[i]    <= lq_if.i_alloc_lsu_func;
        entry_addr[i]    <= lq_if.i_alloc_addr;
        entry_tag[i]     <= lq_if.i_alloc_tag;
        entry_misspec[i] <= 1'b0;
      end else if (sq_hit[i]) begin
        entry_misspec[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || i_flush)          replay_en <= 1'b0;
    else if (!lq_if.i_replay_stall) replay_en <= |replay_select;
  end

  always_ff @(posedge clk) begin
    if (!lq_if.i_replay_stall) begin
      replay_select_q <= replay_select;
      replay_func_q   <= replay_func_mux;
      replay_addr_q   <= replay_addr_mux;
      replay_tag_q    <= replay_tag_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_rob_retire_ack           <= 1'b0;
      o_rob_retire_misspeculated <= 1'b0;
    end else begin
      o_rob_retire_ack           <= retire_ack_next;
      o_rob_retire_misspeculated <= retire_misspec_next;
    end
  end

  assign lq_if.o_alloc_select    = alloc_select;
  assign lq_if.o_replay_en       = replay_en;
  assign lq_if.o_replay_select   = replay_select_q;
  assign lq_if.o_replay_lsu_func = replay_func_q;
  assign lq_if.o_replay_addr     = replay_addr_q;
  assign lq_if.o_replay_tag      = replay_tag_q;

`ifdef PCYN_LQ_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_misspec_count <= '0;
      o_replay_count  <= '0;
    end else begin
      if (retire_ack_next && retire_misspec_next) o_misspec_count <= o_misspec_count + 32'd1;
      if (!i_flush && (|replay_select))           o_replay_count  <= o_replay_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_procyon_lsu_lq.sv
// Directed self-checking bench for procyon_lsu_lq.
module tb_procyon_lsu_lq;
  import procyon_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_flush;
  logic        o_full;
  logic        i_mhq_fill_en;
  logic        i_sq_retire_en;
  logic [31:0] i_sq_retire_addr;
  logic [3:0]  i_sq_retire_lsu_func;
  logic        i_rob_retire_en;
  logic [4:0]  i_rob_retire_tag;
  logic        o_rob_retire_ack;
  logic        o_rob_retire_misspeculated;
`ifdef PCYN_LQ_PERF_COUNTERS_EN
  logic [31:0] o_misspec_count;
  logic [31:0] o_replay_count;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  procyon_lsu_lq_if #(.OPTN_ADDR_WIDTH(32), .OPTN_LQ_DEPTH(8), .OPTN_ROB_IDX_WIDTH(5)) lq_if ();

  procyon_lsu_lq #(
    .OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32), .OPTN_LQ_DEPTH(8), .OPTN_ROB_IDX_WIDTH(5)
  ) dut (
    .clk                       (clk),
    .n_rst                     (n_rst),
    .i_flush                   (i_flush),
    .o_full                    (o_full),
    .lq_if                     (lq_if.slave),
    .i_mhq_fill_en             (i_mhq_fill_en),
    .i_sq_retire_en            (i_sq_retire_en),
    .i_sq_retire_addr          (i_sq_retire_addr),
    .i_sq_retire_lsu_func      (i_sq_retire_lsu_func),
    .i_rob_retire_en           (i_rob_retire_en),
    .i_rob_retire_tag          (i_rob_retire_tag),
    .o_rob_retire_ack          (o_rob_retire_ack),
    .o_rob_retire_misspeculated(o_rob_retire_misspeculated)
`ifdef PCYN_LQ_PERF_COUNTERS_EN
    ,
    .o_misspec_count           (o_misspec_count),
    .o_replay_count            (o_replay_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_flush                  = 1'b0;
    i_mhq_fill_en            = 1'b0;
    i_sq_retire_en           = 1'b0;
    i_sq_retire_addr         = '0;
    i_sq_retire_lsu_func     = '0;
    i_rob_retire_en          = 1'b0;
    i_rob_retire_tag         = '0;
    lq_if.i_alloc_en         = 1'b0;
    lq_if.i_alloc_lsu_func   = '0;
    lq_if.i_alloc_tag        = '0;
    lq_if.i_alloc_addr       = '0;
    lq_if.i_replay_stall     = 1'b0;
    lq_if.i_update_en        = 1'b0;
    lq_if.i_update_select    = '0;
    lq_if.i_update_retry     = 1'b0;
    lq_if.i_update_mhq_retry = 1'b0;
  endtask

  task automatic set_alloc(input logic [3:0] func, input logic [31:0] addr, input logic [4:0] tag);
    lq_if.i_alloc_en       = 1'b1;
    lq_if.i_alloc_lsu_func = func;
    lq_if.i_alloc_addr     = addr;
    lq_if.i_alloc_tag      = tag;
  endtask

  task automatic do_alloc(input logic [3:0] func, input logic [31:0] addr, input logic [4:0] tag);
    set_alloc(func, addr, tag);
    tick();
    lq_if.i_alloc_en = 1'b0;
  endtask

  task automatic do_update(input logic [7:0] sel, input logic retry, input logic mhq, input logic fill);
    lq_if.i_update_en        = 1'b1;
    lq_if.i_update_select    = sel;
    lq_if.i_update_retry     = retry;
    lq_if.i_update_mhq_retry = mhq;
    i_mhq_fill_en            = fill;
    tick();
    lq_if.i_update_en = 1'b0;
    i_mhq_fill_en     = 1'b0;
  endtask

  task automatic do_retire(input logic [4:0] tag);
    i_rob_retire_en  = 1'b1;
    i_rob_retire_tag = tag;
    tick();
    i_rob_retire_en = 1'b0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    idle_inputs();
    n_rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL reset_replay_en: got %0b required 0", lq_if.o_replay_en);
    end
    n_checks++;
    if (o_rob_retire_ack !== 1'b0 || o_rob_retire_misspeculated !== 1'b0) begin
      n_fails++; $display("FAIL reset_retire: got ack %0b misspec %0b required 0 0",
                          o_rob_retire_ack, o_rob_retire_misspeculated);
    end
    n_checks++;
    if (o_full !== 1'b0 || lq_if.o_alloc_select !== 8'h00) begin
      n_fails++; $display("FAIL reset_full: got full %0b sel %0h required 0 0", o_full, lq_if.o_alloc_select);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_alloc(PCYN_LSU_FUNC_LW, 32'h100, 5'd3);
    #1;
    n_checks++;
    if (lq_if.o_alloc_select !== 8'h01 || o_full !== 1'b0) begin
      n_fails++; $display("FAIL basic_alloc: got sel %0h full %0b required 1 0", lq_if.o_alloc_select, o_full);
    end
    tick();
    lq_if.i_alloc_en = 1'b0;
    do_update(8'h01, 1'b0, 1'b0, 1'b0);
    do_retire(5'd3);
    n_checks++;
    if (o_rob_retire_ack !== 1'b1 || o_rob_retire_misspeculated !== 1'b0) begin
      n_fails++; $display("FAIL basic_retire: got ack %0b misspec %0b required 1 0",
                          o_rob_retire_ack, o_rob_retire_misspeculated);
    end
    do_retire(5'd3);
    n_checks++;
    if (o_rob_retire_ack !== 1'b0) begin
      n_fails++; $display("FAIL basic_retire_again: got ack %0b required 0", o_rob_retire_ack);
    end
  endtask

  // when: 0 store after load completes, 1 store with ROB retire, 2 store with allocation
  task automatic test_misspec();
    logic [3:0]  st_func [5] = '{PCYN_LSU_FUNC_SH, PCYN_LSU_FUNC_SB, PCYN_LSU_FUNC_SW,
                                 PCYN_LSU_FUNC_SB, PCYN_LSU_FUNC_SW};
    logic [31:0] st_addr [5] = '{32'h100, 32'h102, 32'h100, 32'h105, 32'h100};
    int          st_when [5] = '{0, 0, 1, 0, 2};
    logic        exp_ms  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      if (st_when[c] == 2) begin
        i_sq_retire_en       = 1'b1;
        i_sq_retire_addr     = st_addr[c];
        i_sq_retire_lsu_func = st_func[c];
      end
      do_alloc(PCYN_LSU_FUNC_LB, 32'h101, 5'd4);
      i_sq_retire_en = 1'b0;
      do_update(8'h01, 1'b0, 1'b0, 1'b0);
      if (st_when[c] != 2) begin
        i_sq_retire_en       = 1'b1;
        i_sq_retire_addr     = st_addr[c];
        i_sq_retire_lsu_func = st_func[c];
        if (st_when[c] == 0) begin
          tick();
          i_sq_retire_en = 1'b0;
        end
      end
      do_retire(5'd4);
      i_sq_retire_en = 1'b0;
      n_checks++;
      if (o_rob_retire_ack !== 1'b1 || o_rob_retire_misspeculated !== exp_ms[c]) begin
        n_fails++; $display("FAIL misspec_case%0d: got ack %0b misspec %0b required 1 %0b",
                            c, o_rob_retire_ack, o_rob_retire_misspeculated, exp_ms[c]);
      end
    end
  endtask

  task automatic test_mhq_replay();
    do_alloc(PCYN_LSU_FUNC_LW, 32'h200, 5'd7);
    do_update(8'h01, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (lq_if.o_replay_en !== 1'b0) begin
        n_fails++; $display("FAIL mhq_wait_%0d: got replay_en %0b required 0", k, lq_if.o_replay_en);
      end
    end
    i_mhq_fill_en = 1'b1;
    tick();
    i_mhq_fill_en = 1'b0;
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL mhq_fill_edge: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_select !== 8'h01 || lq_if.o_replay_addr !== 32'h200 ||
        lq_if.o_replay_tag !== 5'd7 || lq_if.o_replay_lsu_func !== PCYN_LSU_FUNC_LW) begin
      n_fails++; $display("FAIL mhq_replay: got en %0b sel %0h addr %0h tag %0d func %0d required 1 1 200 7 %0d",
                          lq_if.o_replay_en, lq_if.o_replay_select, lq_if.o_replay_addr,
                          lq_if.o_replay_tag, lq_if.o_replay_lsu_func, PCYN_LSU_FUNC_LW);
    end
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL mhq_replay_once: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    do_flush();
    do_alloc(PCYN_LSU_FUNC_LH, 32'h204, 5'd8);
    do_update(8'h01, 1'b1, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_tag !== 5'd8 || lq_if.o_replay_addr !== 32'h204) begin
      n_fails++; $display("FAIL mhq_bypass: got en %0b tag %0d addr %0h required 1 8 204",
                          lq_if.o_replay_en, lq_if.o_replay_tag, lq_if.o_replay_addr);
    end
    do_flush();
  endtask

  task automatic test_full();
    logic [7:0] exp_sel;
    for (int k = 0; k < 8; k++) begin
      set_alloc(PCYN_LSU_FUNC_LW, 32'h300 + 32'(4 * k), 5'(10 + k));
      #1;
      exp_sel = 8'd1 << k;
      n_checks++;
      if (lq_if.o_alloc_select !== exp_sel || o_full !== (k == 7)) begin
        n_fails++; $display("FAIL full_alloc%0d: got sel %0h full %0b required %0h %0b",
                            k, lq_if.o_alloc_select, o_full, exp_sel, (k == 7));
      end
      tick();
    end
    lq_if.i_alloc_en = 1'b0;
    #1;
    n_checks++;
    if (o_full !== 1'b1) begin
      n_fails++; $display("FAIL full_idle: got full %0b required 1", o_full);
    end
    do_update(8'h04, 1'b0, 1'b0, 1'b0);
    do_retire(5'd12);
    n_checks++;
    if (o_rob_retire_ack !== 1'b1 || o_full !== 1'b0) begin
      n_fails++; $display("FAIL full_free: got ack %0b full %0b required 1 0", o_rob_retire_ack, o_full);
    end
    set_alloc(PCYN_LSU_FUNC_LW, 32'h380, 5'd18);
    #1;
    n_checks++;
    if (lq_if.o_alloc_select !== 8'h04 || o_full !== 1'b1) begin
      n_fails++; $display("FAIL full_reuse: got sel %0h full %0b required 4 1", lq_if.o_alloc_select, o_full);
    end
    tick();
    lq_if.i_alloc_en = 1'b0;
    do_flush();
  endtask

  task automatic test_replay_stall();
    for (int k = 0; k < 6; k++) do_alloc(PCYN_LSU_FUNC_LW, 32'h400 + 32'(4 * k), 5'(20 + k));
    lq_if.i_replay_stall = 1'b1;
    do_update(8'h02, 1'b1, 1'b0, 1'b0);
    do_update(8'h20, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL stall_hold0: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL stall_hold1: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    lq_if.i_replay_stall = 1'b0;
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_select !== 8'h02 || lq_if.o_replay_tag !== 5'd21 ||
        lq_if.o_replay_addr !== 32'h404) begin
      n_fails++; $display("FAIL stall_first: got en %0b sel %0h tag %0d addr %0h required 1 2 21 404",
                          lq_if.o_replay_en, lq_if.o_replay_select, lq_if.o_replay_tag, lq_if.o_replay_addr);
    end
    lq_if.i_replay_stall = 1'b1;
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_select !== 8'h02 || lq_if.o_replay_tag !== 5'd21) begin
      n_fails++; $display("FAIL stall_held: got en %0b sel %0h tag %0d required 1 2 21",
                          lq_if.o_replay_en, lq_if.o_replay_select, lq_if.o_replay_tag);
    end
    lq_if.i_replay_stall = 1'b0;
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_select !== 8'h20 || lq_if.o_replay_tag !== 5'd25 ||
        lq_if.o_replay_addr !== 32'h414) begin
      n_fails++; $display("FAIL stall_second: got en %0b sel %0h tag %0d addr %0h required 1 20 25 414",
                          lq_if.o_replay_en, lq_if.o_replay_select, lq_if.o_replay_tag, lq_if.o_replay_addr);
    end
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL stall_drain: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    do_flush();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) do_alloc(PCYN_LSU_FUNC_LW, 32'h500 + 32'(4 * k), 5'(11 + k));
    do_update(8'h02, 1'b0, 1'b0, 1'b0);
    do_update(8'h04, 1'b1, 1'b1, 1'b0);
    do_update(8'h08, 1'b1, 1'b0, 1'b0);
    do_update(8'h10, 1'b1, 1'b0, 1'b0);
    lq_if.i_replay_stall = 1'b1;
    n_checks++;
    if (lq_if.o_replay_en !== 1'b1 || lq_if.o_replay_select !== 8'h08) begin
      n_fails++; $display("FAIL flush_pre: got en %0b sel %0h required 1 8",
                          lq_if.o_replay_en, lq_if.o_replay_select);
    end
    do_flush();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL flush_replay_en: got %0b required 0", lq_if.o_replay_en);
    end
    lq_if.i_replay_stall = 1'b0;
    i_mhq_fill_en = 1'b1;
    do_retire(5'd12);
    i_mhq_fill_en = 1'b0;
    n_checks++;
    if (o_rob_retire_ack !== 1'b0 || lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL flush_old_tag: got ack %0b replay_en %0b required 0 0",
                          o_rob_retire_ack, lq_if.o_replay_en);
    end
    tick();
    n_checks++;
    if (lq_if.o_replay_en !== 1'b0) begin
      n_fails++; $display("FAIL flush_no_replay: got replay_en %0b required 0", lq_if.o_replay_en);
    end
    set_alloc(PCYN_LSU_FUNC_LW, 32'h600, 5'd1);
    #1;
    n_checks++;
    if (lq_if.o_alloc_select !== 8'h01 || o_full !== 1'b0) begin
      n_fails++; $display("FAIL flush_empty: got sel %0h full %0b required 1 0", lq_if.o_alloc_select, o_full);
    end
    tick();
    lq_if.i_alloc_en = 1'b0;
  endtask

  // Final report
  initial begin
    test_reset();
    test_basic();
    test_misspec();
    test_mhq_replay();
    test_full();
    test_replay_stall();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/procyon_lsu_lq.md
Name: procyon_lsu_lq

Overview:
- Load queue for the LSU.
- Tracks every in-flight load from issue until ROB retirement, and replays loads that missed or need a retry.
- Consumes the store queue's retiring-store broadcast to detect loads that read stale data.
- Reports mis-speculation to the ROB when the offending load retires.

Parameters:
OPTN_DATA_WIDTH, 32, data width
OPTN_ADDR_WIDTH, 32, address width
OPTN_LQ_DEPTH, 8, number of entries (power of two)
OPTN_ROB_IDX_WIDTH, 5, ROB tag width

Ports:
clk  in  1  clock
n_rst  in  1  synchronous active-low reset
i_flush  in  1  pipeline flush
o_full  out  1  no empty entry after this cycle's allocation (combinational)
i_alloc_en  in  1  allocate load (issued and launched this cycle)
i_alloc_lsu_func  in  PCYN_LSU_FUNC_WIDTH  load type
i_alloc_tag  in  OPTN_ROB_IDX_WIDTH  ROB tag
i_alloc_addr  in  OPTN_ADDR_WIDTH  load address
o_alloc_select  out  OPTN_LQ_DEPTH  one-hot allocated entry (combinational)
i_replay_stall  in  1  LSU cannot accept replay
o_replay_en  out  1  replayed load valid
o_replay_select  out  OPTN_LQ_DEPTH  one-hot replayed entry
o_replay_lsu_func  out  PCYN_LSU_FUNC_WIDTH  replayed load type
o_replay_addr  out  OPTN_ADDR_WIDTH  replayed address
o_replay_tag  out  OPTN_ROB_IDX_WIDTH  replayed tag
i_update_en  in  1  LSU result for a launched load
i_update_select  in  OPTN_LQ_DEPTH  one-hot entry updated
i_update_retry  in  1  load must be retried
i_update_mhq_retry  in  1  retry after MHQ fill
i_mhq_fill_en  in  1  MHQ fill broadcast
i_sq_retire_en  in  1  store retiring to memory
i_sq_retire_addr  in  OPTN_ADDR_WIDTH  store address
i_sq_retire_lsu_func  in  PCYN_LSU_FUNC_WIDTH  store type
i_rob_retire_en  in  1  ROB retiring a load
i_rob_retire_tag  in  OPTN_ROB_IDX_WIDTH  retiring tag
o_rob_retire_ack  out  1  load found complete, freed
o_rob_retire_misspeculated  out  1  freed load read stale data

Behaviour:
- Entry states:
  - INVALID.
  - LAUNCHED: in LSU pipeline.
  - MHQ_FILL_WAIT.
  - REPLAYABLE.
  - COMPLETE: data written back, awaiting ROB.
  - Unused encodings go to INVALID.
- Entry fields: lsu_func, addr, tag, misspec bit.
- Allocation:
  - Lowest-index INVALID entry, written when i_alloc_en.
  - INVALID->LAUNCHED, misspec cleared.
  - o_full = ((empty & ~alloc_select) == 0).
- Update on the selected LAUNCHED entry:
  - No retry -> COMPLETE.
  - retry & mhq_retry -> MHQ_FILL_WAIT, or REPLAYABLE if i_mhq_fill_en in the same cycle (bypass).
  - retry only -> REPLAYABLE.
- MHQ_FILL_WAIT -> REPLAYABLE on i_mhq_fill_en.
- Replay:
  - Lowest-index REPLAYABLE entry, chosen only when ~i_replay_stall; that entry goes REPLAYABLE->LAUNCHED.
  - Outputs registered (1-cycle latency) and held while i_replay_stall.
  - o_replay_en is 0 on reset/flush.
- Mis-speculation:
  - Triggers when i_sq_retire_en and an entry is LAUNCHED or COMPLETE with byte overlap: equal addr[W-1:2] and (load_mask & store_mask) != 0.
  - Mask = size mask (B=4'b0001, H=4'b0011, W=4'b1111) << addr[1:0].
  - On trigger, set misspec.
  - Entries in MHQ_FILL_WAIT/REPLAYABLE are not flagged; they re-read later.
  - A store broadcast in the same cycle as an allocation to the same entry does not flag the new load.
- ROB retire:
  - Matches a COMPLETE entry by tag -> INVALID.
  - o_rob_retire_ack and o_rob_retire_misspeculated are registered, 1 cycle later.
  - Misspec output includes a same-cycle SQ overlap on that entry.
  - No match -> ack 0.
- Flush: every non-INVALID entry -> INVALID next cycle. Flush has priority over allocate/update/fill.
- Reset: all entries INVALID; o_replay_en, o_rob_retire_ack, o_rob_retire_misspeculated = 0. Data-path outputs are not reset.
- Update on a non-LAUNCHED entry is ignored.

Optional Feature:
- Macro: PCYN_LQ_PERF_COUNTERS_EN.
- When defined:
  - Adds ports o_misspec_count (out, 32) and o_replay_count (out, 32).
  - Counters increment on each acked misspeculated retire and each issued replay respectively, wrap at 2^32, reset to 0, are not cleared by flush.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Add LQ state encodings, byte-mask width, and lsu_func-to-size mapping to shared package procyon_lsu_pkg.
- PCYN_LSU_FUNC_* encodings remain in procyon_constants.svh.
- One sub-module: procyon_lsu_lq_overlap (combinational, load addr/func vs store addr/func -> overlap bit), instantiated per entry.

Test Plan:
- Alloc LW 0x100 tag 3, update no-retry, ROB retire tag 3 -> ack=1, misspec=0 next cycle; entry INVALID.
- Alloc LB 0x101 tag 4, update no-retry, SQ retire SH 0x100 -> ROB retire tag 4 gives ack=1, misspec=1; SB 0x102 instead gives misspec=0.
- Update retry+mhq_retry with i_mhq_fill_en=0, fill 3 cycles later -> o_replay_en=1, addr/tag of entry, one cycle after fill+1; same with fill same cycle as update -> replay without waiting.
- Fill all 8 entries -> o_full=1 during 8th allocation; retire one -> o_full drops next cycle; alloc reuses freed index.
- Two REPLAYABLE entries (1, 5) with i_replay_stall=1 for 2 cycles -> outputs held; release -> entry 1 replays, then entry 5.
- Flush with entries in every state -> all INVALID, o_replay_en=0 next cycle; ROB retire of old tag -> ack=0.
